tx_payload_buffer: RTL and testbench
====================================

Name: tx_payload_buffer

Overview:
Frame-oriented byte FIFO directly upstream of the Ethernet TX framer. The MAC client writes payload bytes and marks each frame end. Once a complete frame is committed, the buffer offers it with a buffer_ready / data_recive handshake. It then streams the frame one byte per clock on data_out/read_en and closes with a one-cycle buffer_empt strobe.

Parameters:
DEPTH, 2048, payload byte storage; power of two.
ADDR_W, 11, log2(DEPTH).
MAX_LEN, 1500, longest accepted payload in bytes.
LEN_FIFO_DEPTH, 4, committed frames that can queue; power of two.

Ports:
clk  in  1  single system clock.
rst  in  1  asynchronous, active-low reset.
wr_data  in  8  client payload byte.
wr_en  in  1  wr_data valid this cycle.
wr_last  in  1  with wr_en: this byte ends the frame.
frame_drop  out  1  one-cycle pulse when a frame is discarded.
data_recive  in  1  framer accepts the offered frame.
buffer_ready  out  1  a complete frame is offered.
data_out  out  8  streamed payload byte.
read_en  out  1  data_out valid this cycle.
buffer_empt  out  1  one-cycle pulse after the last streamed byte.
frame_len  out  11  length of the offered or streaming frame.

Behaviour:
- Reset (rst=0, async): all outputs 0; write/read/commit pointers 0; length FIFO empty; FSM IDLE. Reset mid-frame loses partial and queued frames without a drop pulse.
- Write side:
  - wr_en stores a byte at wr_ptr and increments wr_ptr (mod DEPTH) and wr_cnt.
  - wr_en&wr_last commits the frame. The length (wr_cnt incl. this byte) is pushed into the length FIFO, commit_ptr becomes wr_ptr+1, and wr_cnt clears.
- Drop conditions, all evaluated on the offending write:
  - byte would make wr_cnt > MAX_LEN;
  - storage full (wr_ptr+1 == rd_ptr);
  - wr_last while the length FIFO is full.
- Drop action:
  - wr_ptr rolls back to commit_ptr and frame_drop pulses next cycle.
  - Remaining bytes up to and including wr_last are ignored (discard flag). The discard flag clears on wr_last.
  - A frame that overflows on its wr_last byte also drops.
- Read FSM:
  - IDLE: if the length FIFO is non-empty, latch the head length into frame_len. Go to OFFER next cycle.
  - OFFER: buffer_ready=1 until data_recive is sampled high in cycle N. Then buffer_ready=0 and go to STREAM; the length FIFO pops.
  - STREAM: data_out is registered from memory. Byte k is on data_out with read_en=1 in cycle N+1+k, k=0..L-1, and rd_ptr increments per byte. No back-pressure.
  - DONE: cycle N+L+1, read_en=0, buffer_empt=1. Next cycle go to IDLE; back-to-back frames are re-offered from cycle N+L+3.
- Simultaneous write and read are legal. Space freed by a read is visible to the write-side full check the next cycle.
- Pointer wrap at DEPTH is transparent. frame_len is held during STREAM/DONE and is 0 in IDLE.
- data_recive outside OFFER is ignored.

Optional Feature:
TXBUF_STATS_EN
- Defined: adds outputs stat_frames[15:0] (incremented at each DONE) and stat_drops[15:0] (incremented with each frame_drop). Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package eth_pkg holds:
  - FSM state encoding IDLE/OFFER/STREAM/DONE;
  - MIN_PAYLOAD=46, MAX_PAYLOAD=1500;
  - LEN_W=11.
- The framer uses the same constants.
- One sub-module, txbuf_len_fifo: synchronous FIFO, LEN_W wide, LEN_FIFO_DEPTH deep, with push/pop/full/empty. It is reused later on the RX side.

Test Plan:
1. Write 46 bytes 0x00..0x2D, wr_last on the last byte; ack data_recive 3 cycles after buffer_ready.
   - Expect frame_len=46, read_en high 46 consecutive cycles carrying 0x00..0x2D, then buffer_empt for one cycle.
2. Write a 1501-byte frame.
   - Expect frame_drop one cycle after byte 1501, buffer_ready never asserted.
   - A following 60-byte frame streams intact.
3. Commit 4 one-byte frames, then attempt a 5th with the length FIFO full.
   - Expect the 5th dropped; the 4 frames are offered in order with frame_len=1 each.
4. Hold rst=0 mid-STREAM (byte 10 of 100).
   - Expect all outputs 0 asynchronously; after release no buffer_ready until a new frame is committed.
5. Write frame B (1500 bytes) while frame A streams, with pointers starting at 2000.
   - Expect correct wrap past DEPTH and B's bytes intact.
6. With TXBUF_STATS_EN defined, run 3 good frames and 2 drops.
   - Expect stat_frames=3 and stat_drops=2.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Shared Ethernet TX constants and read-FSM state encoding.
package eth_pkg;

  localparam int LEN_W       = 11;
  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } txbuf_state_t;

endpackage

// File: rtl/txbuf_len_fifo.sv
// rtl/txbuf_len_fifo.sv - Synchronous FIFO of committed frame lengths, head visible combinationally.
module txbuf_len_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [LEN_W-1:0] push_data,
  input  logic             pop,
  output logic [LEN_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tx_payload_buffer.sv
// rtl/tx_payload_buffer.sv - Frame byte FIFO feeding the TX framer; TXBUF_STATS_EN adds frame/drop counters.
module tx_payload_buffer
  import eth_pkg::*;
#(
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = 11,
  parameter int MAX_LEN        = MAX_PAYLOAD,
  parameter int LEN_FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             wr_last,
  output logic             frame_drop,
  input  logic             data_recive,
  output logic             buffer_ready,
  output logic [7:0]       data_out,
  output logic             read_en,
  output logic             buffer_empt,
  output logic [LEN_W-1:0] frame_len
`ifdef TXBUF_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_drops
`endif
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] commit_ptr;
  logic [LEN_W-1:0]  wr_cnt;
  logic [LEN_W-1:0]  rd_cnt;
  logic              discard;
  txbuf_state_t      state;
  txbuf_state_t      state_nxt;

  logic              wr_take;
  logic              drop_now;
  logic              commit;
  logic              accept;
  logic              lf_full;
  logic              lf_empty;
  logic [LEN_W-1:0]  lf_head;

  assign wr_take  = wr_en && !discard;
  assign drop_now = wr_take && ((wr_cnt >= LEN_W'(MAX_LEN)) ||
                                ((wr_ptr + ADDR_W'(1)) == rd_ptr) ||
                                (wr_last && lf_full));
  assign commit   = wr_take && wr_last && !drop_now;
  assign accept   = (state == OFFER) && data_recive;

  txbuf_len_fifo #(.DEPTH(LEN_FIFO_DEPTH)) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (commit),
    .push_data (wr_cnt + LEN_W'(1)),
    .pop       (accept),
    .head      (lf_head),
    .full      (lf_full),
    .empty     (lf_empty)
  );

  // A drop rewinds to the last committed frame; discard swallows the rest of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wr_cnt     <= '0;
      discard    <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= drop_now;
      if (drop_now) begin
        wr_ptr  <= commit_ptr;
        wr_cnt  <= '0;
        discard <= !wr_last;
      end else if (wr_take) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_last) begin
          commit_ptr <= wr_ptr + ADDR_W'(1);
          wr_cnt     <= '0;
        end else begin
          wr_cnt <= wr_cnt + LEN_W'(1);
        end
      end else if (wr_en && wr_last) begin
        discard <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_take && !drop_now) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!lf_empty) state_nxt = OFFER;
      OFFER:   if (data_recive) state_nxt = STREAM;
      STREAM:  if (rd_cnt == frame_len) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign buffer_ready = (state == OFFER);
  assign read_en      = (state == STREAM);
  assign buffer_empt  = (state == DONE);

  // Byte 0 is fetched on the accepting edge so it is on data_out in the first STREAM cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      data_out  <= '0;
      frame_len <= '0;
    end else begin
      case (state)
        IDLE: if (!lf_empty) frame_len <= lf_head;
        OFFER: begin
          if (data_recive) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_W'(1);
            rd_cnt   <= LEN_W'(1);
          end
        end
        STREAM: begin
          if (rd_cnt != frame_len) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_W'(1);
            rd_cnt   <= rd_cnt + LEN_W'(1);
          end else begin
            data_out <= '0;
          end
        end
        DONE: frame_len <= '0;
        default: frame_len <= '0;
      endcase
    end
  end

`ifdef TXBUF_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      if (buffer_empt && (stat_frames != 16'hFFFF)) stat_frames <= stat_frames + 16'd1;
      if (frame_drop && (stat_drops != 16'hFFFF))   stat_drops  <= stat_drops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_payload_buffer.sv
// tb/tb_tx_payload_buffer.sv - Scoreboard bench for tx_payload_buffer (stats checked when TXBUF_STATS_EN).
module tb_tx_payload_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_en = 1'b0;
  logic        wr_last = 1'b0;
  logic        frame_drop;
  logic        data_recive;
  logic        buffer_ready;
  logic [7:0]  data_out;
  logic        read_en;
  logic        buffer_empt;
  logic [10:0] frame_len;
`ifdef TXBUF_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_drops;
`endif

  tx_payload_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_last      (wr_last),
    .frame_drop   (frame_drop),
    .data_recive  (data_recive),
    .buffer_ready (buffer_ready),
    .data_out     (data_out),
    .read_en      (read_en),
    .buffer_empt  (buffer_empt),
    .frame_len    (frame_len)
`ifdef TXBUF_STATS_EN
    ,
    .stat_frames  (stat_frames),
    .stat_drops   (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] exp_bytes [$];
  int         exp_lens  [$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         drops_seen   = 0;
  int         exp_drops    = 0;
  int         exp_frames   = 0;
  int         run_cnt      = 0;
  int         cur_len      = 0;
  bit         mon_en       = 1'b0;
  bit         ack_en       = 1'b0;
  int         ack_dly      = 3;
  bit         prev_ready   = 1'b0;
  bit         prev_empt    = 1'b0;
  bit         prev_re      = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_drop) drops_seen++;
      if (buffer_ready && !prev_ready) begin
        if (exp_lens.size() == 0) check_eq("spurious_offer", 1, 0);
        else begin
          cur_len = exp_lens.pop_front();
          check_eq("frame_len", frame_len, cur_len);
        end
        run_cnt = 0;
      end
      if (read_en) begin
        run_cnt++;
        check_eq("len_held", frame_len, cur_len);
        if (exp_bytes.size() == 0) check_eq("extra_byte", 1, 0);
        else check_eq("data_out", data_out, exp_bytes.pop_front());
      end
      if (prev_re && !read_en) check_eq("stream_end_empt", buffer_empt, 1);
      if (buffer_empt) check_eq("stream_run", run_cnt, cur_len);
      if (prev_empt) check_eq("empt_pulse", buffer_empt, 0);
      prev_ready = buffer_ready;
      prev_empt  = buffer_empt;
      prev_re    = read_en;
    end
  end

  initial begin : acker
    int cnt;
    cnt = 0;
    data_recive = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && buffer_ready) begin
        cnt++;
        data_recive = (cnt >= ack_dly);
      end else begin
        cnt = 0;
        data_recive = 1'b0;
      end
    end
  end

  task automatic send_frame(input int len, input int seed, input bit good, input bit drop_last);
    for (int i = 0; i < len; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(seed + i);
      wr_last = (i == len - 1);
      if (good) exp_bytes.push_back(8'(seed + i));
      @(posedge clk);
      #1;
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
    if (good) begin
      exp_lens.push_back(len);
      exp_frames++;
    end
    @(negedge clk);
    check_eq("frame_drop", frame_drop, drop_last);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_lens.size() != 0 || exp_bytes.size() != 0 || buffer_ready || read_en || buffer_empt)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", buffer_ready, 0);
    check_eq("rst_read_en", read_en, 0);
    check_eq("rst_empt", buffer_empt, 0);
    check_eq("rst_drop", frame_drop, 0);
    check_eq("rst_len", frame_len, 0);
    check_eq("rst_data", data_out, 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    ack_en = 1'b1;
    @(posedge clk);
    #1;

    // 46-byte minimum frame, ack three cycles into the offer
    ack_dly = 3;
    send_frame(46, 0, 1, 0);
    wait_drain(500);

    // oversize frame dropped on its last byte, then a good one
    send_frame(1501, 8'h33, 0, 1);
    exp_drops++;
    send_frame(60, 8'h80, 1, 0);
    wait_drain(500);
    check_eq("drops_t2", drops_seen, exp_drops);

    // length FIFO full: four one-byte frames queue, fifth drops
    ack_en  = 1'b0;
    ack_dly = 1;
    for (int k = 0; k < 4; k++) send_frame(1, 8'h10 + k, 1, 0);
    send_frame(1, 8'hAA, 0, 1);
    exp_drops++;
    ack_en = 1'b1;
    wait_drain(500);
    check_eq("drops_t3", drops_seen, exp_drops);

    // asynchronous reset in the middle of a 100-byte stream
    ack_dly = 2;
    run_cnt = 0;
    send_frame(100, 8'h40, 1, 0);
    n = 0;
    while (run_cnt < 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) check_eq("rst_wait_timeout", 1, 0);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_ready", buffer_ready, 0);
    check_eq("arst_read_en", read_en, 0);
    check_eq("arst_empt", buffer_empt, 0);
    check_eq("arst_drop", frame_drop, 0);
    check_eq("arst_len", frame_len, 0);
    check_eq("arst_data", data_out, 0);
    exp_bytes.delete();
    exp_lens.delete();
    drops_seen = 0;
    exp_drops  = 0;
    exp_frames = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq("no_offer_after_rst", buffer_ready, 0);
    end
    prev_ready = 1'b0;
    prev_empt  = 1'b0;
    prev_re    = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk);
    #1;

    // three good frames and two drops (one with trailing discarded bytes)
    send_frame(46, 8'h05, 1, 0);
    send_frame(1501, 8'h21, 0, 1);
    exp_drops++;
    send_frame(64, 8'hC0, 1, 0);
    send_frame(1510, 8'h61, 0, 0);
    exp_drops++;
    send_frame(10, 8'hF8, 1, 0);
    wait_drain(1000);
    check_eq("drops_t6", drops_seen, exp_drops);
`ifdef TXBUF_STATS_EN
    check_eq("stat_frames", stat_frames, exp_frames);
    check_eq("stat_drops", stat_drops, exp_drops);
`endif

    // move pointers to 2000, then write B while A streams across the wrap
    send_frame(1500, 8'h07, 1, 0);
    wait_drain(3000);
    send_frame(380, 8'h19, 1, 0);
    wait_drain(1000);
    send_frame(200, 8'h5A, 1, 0);
    send_frame(1500, 8'h9C, 1, 0);
    wait_drain(5000);
    check_eq("drops_t5", drops_seen, exp_drops);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
